// File: rtl/iob_ram_be_arbiter.sv
// Round-robin arbiter sharing one byte-enabled RAM port (1-cycle registered read) among N_REQ
// requesters. Define IOB_RAM_BE_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module iob_ram_be_arbiter #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb_i,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [N_REQ-1:0]           rsp_valid_o,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       ram_en_o,
    output logic [DATA_W/8-1:0]        ram_we_o,
    output logic [ADDR_W-1:0]          ram_addr_o,
    output logic [DATA_W-1:0]          ram_d_o,
    input  logic [DATA_W-1:0]          ram_d_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]  w_idx;
    logic              w_found;
    logic [STRB_W-1:0] w_strb;
    logic              w_is_read;
    logic [N_REQ-1:0]  r_rd_pend;

`ifndef IOB_RAM_BE_ARBITER_FIXED_PRIO_EN
    logic [PTR_W-1:0]  r_ptr;
`endif

    always_comb begin
        int j;
        j       = 0;
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (!rst_i) begin
`ifdef IOB_RAM_BE_ARBITER_FIXED_PRIO_EN
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (!w_found && req_valid_i[i]) begin
                    w_found    = 1'b1;
                    w_idx      = PTR_W'(i);
                    w_grant[i] = 1'b1;
                end
            end
`else
            // Search starts one past the last granted index and wraps around.
            for (int i = 1; i <= int'(N_REQ); i++) begin
                j = int'(r_ptr) + i;
                if (j >= int'(N_REQ)) j = j - int'(N_REQ);
                if (!w_found && req_valid_i[j]) begin
                    w_found    = 1'b1;
                    w_idx      = PTR_W'(j);
                    w_grant[j] = 1'b1;
                end
            end
`endif
        end
    end

    assign w_strb    = req_wstrb_i[w_idx*STRB_W +: STRB_W];
    assign w_is_read = (w_strb == '0);

    always_comb begin
        req_ready_o = w_grant;
        ram_en_o    = w_found;
        ram_we_o    = '0;
        ram_addr_o  = '0;
        ram_d_o     = '0;
        if (w_found) begin
            ram_we_o   = w_strb;
            ram_addr_o = req_addr_i[w_idx*ADDR_W +: ADDR_W];
            ram_d_o    = req_wdata_i[w_idx*DATA_W +: DATA_W];
        end
    end

`ifndef IOB_RAM_BE_ARBITER_FIXED_PRIO_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= PTR_W'(N_REQ - 1);
        end else if (w_found) begin
            r_ptr <= w_idx;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_pend <= '0;
        end else begin
            r_rd_pend <= w_grant & {N_REQ{w_is_read}};
        end
    end

    // Responses are suppressed while reset is asserted so a read issued just before reset
    // never produces a pulse.
    assign rsp_valid_o = rst_i ? '0 : r_rd_pend;
    assign rsp_rdata_o = (|rsp_valid_o) ? ram_d_i : '0;

endmodule

// File: tb/tb_iob_ram_be_arbiter.sv
// Directed self-checking bench for iob_ram_be_arbiter (N_REQ=2, DATA_W=32, ADDR_W=4)
// with a behavioural byte-enable RAM model providing registered read data.
module tb_iob_ram_be_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [7:0]  req_addr_i;
    logic [7:0]  req_wstrb_i;
    logic [63:0] req_wdata_i;
    logic [1:0]  req_ready_o;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [3:0]  ram_addr_o;
    logic [31:0] ram_d_o;
    logic [31:0] ram_d_i;

    logic [31:0] mem [16];

    int errors = 0;
    int checks = 0;
    int g0;
    int g1;
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;

    always #5 clk = ~clk;

    iob_ram_be_arbiter #(
        .N_REQ (2),
        .DATA_W(32),
        .ADDR_W(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_valid_i(req_valid_i),
        .req_addr_i (req_addr_i),
        .req_wstrb_i(req_wstrb_i),
        .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .ram_en_o   (ram_en_o),
        .ram_we_o   (ram_we_o),
        .ram_addr_o (ram_addr_o),
        .ram_d_o    (ram_d_o),
        .ram_d_i    (ram_d_i)
    );

    always @(posedge clk) begin
        if (ram_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_d_o[b*8 +: 8];
            end
            ram_d_i <= mem[ram_addr_o];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        req_valid_i = '0;
        req_addr_i  = '0;
        req_wstrb_i = '0;
        req_wdata_i = '0;
    endtask

    task automatic drive(input int k, input logic [3:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        req_valid_i[k]          = 1'b1;
        req_addr_i[k*4 +: 4]    = a;
        req_wstrb_i[k*4 +: 4]   = s;
        req_wdata_i[k*32 +: 32] = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clr();
        cyc();
        rst_i = 1'b0;
    endtask

    initial begin
        ram_d_i = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        rst_i = 1'b1;
        clr();
        drive(0, 4'd0, 4'h0, 32'd0);
        drive(1, 4'd1, 4'h0, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 64'(req_ready_o), 64'd0);
            check("rst_en", 64'(ram_en_o), 64'd0);
            check("rst_rsp", 64'(rsp_valid_o), 64'd0);
        end
        cyc();
        rst_i = 1'b0;
        clr();

        @(negedge clk);
        check("idle_en", 64'(ram_en_o), 64'd0);
        check("idle_addr", 64'(ram_addr_o), 64'd0);
        check("idle_rdata", 64'(rsp_rdata_o), 64'd0);
        cyc();

        for (int i = 0; i < 16; i++) begin
            clr();
            drive(0, 4'(i), 4'hF, 32'(32 + i));
            @(negedge clk);
            check("wr_ready", 64'(req_ready_o), 64'd1);
            check("wr_we", 64'(ram_we_o), 64'hF);
            check("wr_rsp", 64'(rsp_valid_o), 64'd0);
            cyc();
        end
        for (int i = 0; i <= 16; i++) begin
            clr();
            if (i < 16) drive(0, 4'(i), 4'h0, 32'd0);
            @(negedge clk);
            if (i > 0) begin
                check("rd_rsp", 64'(rsp_valid_o), 64'd1);
                check("rd_data", 64'(rsp_rdata_o), 64'(32 + i - 1));
            end else begin
                check("rd_rsp0", 64'(rsp_valid_o), 64'd0);
            end
            cyc();
        end

        do_reset();
`ifdef IOB_RAM_BE_ARBITER_FIXED_PRIO_EN
        clr();
        drive(0, 4'd1, 4'h0, 32'd0);
        drive(1, 4'd2, 4'h0, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("fp_ready", 64'(req_ready_o), 64'd1);
            cyc();
        end
        clr();
        drive(1, 4'd2, 4'h0, 32'd0);
        @(negedge clk);
        check("fp_ready1", 64'(req_ready_o), 64'd2);
        cyc();
        clr();
        @(negedge clk);
        check("fp_rsp1", 64'(rsp_valid_o), 64'd2);
        check("fp_data1", 64'(rsp_rdata_o), 64'd34);
        cyc();
`else
        g0 = 0;
        g1 = 0;
        prev_gnt = '0;
        clr();
        drive(0, 4'd1, 4'h0, 32'd0);
        drive(1, 4'd2, 4'h0, 32'd0);
        for (int c = 0; c < 8; c++) begin
            exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            check("rr_ready", 64'(req_ready_o), 64'(exp_gnt));
            if (c > 0) begin
                check("rr_rsp", 64'(rsp_valid_o), 64'(prev_gnt));
                check("rr_data", 64'(rsp_rdata_o), (prev_gnt == 2'b01) ? 64'd33 : 64'd34);
            end
            if (req_ready_o == 2'b01) g0++;
            if (req_ready_o == 2'b10) g1++;
            prev_gnt = exp_gnt;
            cyc();
        end
        clr();
        @(negedge clk);
        check("rr_rsp_last", 64'(rsp_valid_o), 64'd2);
        check("rr_g0", 64'(g0), 64'd4);
        check("rr_g1", 64'(g1), 64'd4);
        cyc();
`endif

        clr();
        drive(0, 4'd5, 4'hF, 32'hAABBCCDD);
        cyc();
        clr();
        drive(0, 4'd5, 4'b0101, 32'h11223344);
        @(negedge clk);
        check("be_we", 64'(ram_we_o), 64'h5);
        cyc();
        clr();
        drive(0, 4'd5, 4'h0, 32'd0);
        cyc();
        clr();
        @(negedge clk);
        check("be_rsp", 64'(rsp_valid_o), 64'd1);
        check("be_data", 64'(rsp_rdata_o), 64'hAA22CC44);
        cyc();

        clr();
        drive(1, 4'd3, 4'hF, 32'd64);
        @(negedge clk);
        check("hz_wr_ready", 64'(req_ready_o), 64'd2);
        cyc();
        clr();
        drive(0, 4'd3, 4'h0, 32'd0);
        @(negedge clk);
        check("hz_rd_ready", 64'(req_ready_o), 64'd1);
        check("hz_no_wr_rsp", 64'(rsp_valid_o), 64'd0);
        cyc();
        clr();
        @(negedge clk);
        check("hz_rsp", 64'(rsp_valid_o), 64'd1);
        check("hz_data", 64'(rsp_rdata_o), 64'd64);
        cyc();

        clr();
        drive(0, 4'd3, 4'h0, 32'd0);
        @(negedge clk);
        check("mr_ready", 64'(req_ready_o), 64'd1);
        cyc();
        rst_i = 1'b1;
        drive(1, 4'd3, 4'h0, 32'd0);
        @(negedge clk);
        check("mr_rsp", 64'(rsp_valid_o), 64'd0);
        check("mr_rdata", 64'(rsp_rdata_o), 64'd0);
        check("mr_ready_rst", 64'(req_ready_o), 64'd0);
        check("mr_en", 64'(ram_en_o), 64'd0);
        cyc();
        rst_i = 1'b0;
        @(negedge clk);
        check("mr_rsp_after", 64'(rsp_valid_o), 64'd0);
        check("mr_first_gnt", 64'(req_ready_o), 64'd1);
        cyc();
        clr();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
